// File: rtl/sensor_ctrl_pkg.sv
// Shared definitions for the sensor sequencer and the UART response packer:
// state encodings, response status codes and a width helper.
package sensor_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RECEIVE  = 3'd1,
      ST_ORGANIZE = 3'd2,
      ST_SEND     = 3'd3,
      ST_WAIT     = 3'd4
   } state_t;

   localparam logic [1:0] STATUS_OK       = 2'b00;
   localparam logic [1:0] STATUS_TIMEOUT  = 2'b01;
   localparam logic [1:0] STATUS_BAD_ADDR = 2'b10;
   localparam logic [1:0] STATUS_STOP_ACK = 2'b11;

   // Bits needed to hold 0..value-1, never less than 1.
   function automatic int clog2_min1(input longint unsigned value);
      int result;
      result = 1;
      for (int i = 1; i < 63; i++)
         if ((64'd1 << i) < value) result = i + 1;
      return result;
   endfunction

endpackage

// File: rtl/sensor_ctrl_fsm_interval_timer.sv
// Shared up-counter: clear restarts the count in the same cycle, tc flags the
// cycle whose count equals the selected terminal value.
module interval_timer #(
   parameter int W = 8
) (
   input  logic         clk_50m,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] term,
   output logic         tc
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cur;

   // A clear in this cycle makes this cycle count zero.
   assign cur = clr ? '0 : cnt_q;
   assign tc  = en && (cur == term);

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= cur + W'(1);
      end
   end

endmodule

// File: rtl/sensor_ctrl_fsm.sv
// Top-level sequencer between the UART command decoder, the sensor reader
// channels and the response packer/transmitter (one-shot or periodic reads).
module sensor_ctrl_fsm
   import sensor_ctrl_pkg::*;
#(
   parameter int N_CH        = 8,
   parameter int ADDR_W      = 8,
   parameter int TIMEOUT_CYC = 5_000_000,
   parameter int PERIOD_CYC  = 100_000_000
) (
   input  logic              clk_50m,
   input  logic              rst_n,
   input  logic              cmd_valid,
   input  logic              cmd_stop,
   input  logic              cmd_cont,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [N_CH-1:0]   sensor_done,
   input  logic              tx_done,
   output logic [N_CH-1:0]   sensor_start,
   output logic              pack,
   output logic              en_request,
   output logic              idle,
   output logic [2:0]        state,
   output logic [1:0]        status,
   output logic              cont_active,
   output logic              cmd_dropped
);

   localparam int CNT_MAX = (TIMEOUT_CYC > PERIOD_CYC) ? TIMEOUT_CYC : PERIOD_CYC;
   localparam int CNT_W   = clog2_min1(longint'(CNT_MAX));
   localparam int CH_W    = clog2_min1(longint'(N_CH));

   localparam logic [CNT_W-1:0]  TIMEOUT_TC = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0]  PERIOD_TC  = CNT_W'(PERIOD_CYC - 1);
   localparam logic [N_CH-1:0]   CH0        = N_CH'(1);
   localparam logic [ADDR_W:0]   N_CH_A     = (ADDR_W + 1)'(N_CH);

   state_t           st;
   logic [CH_W-1:0]  ch;
   logic             tmr_clr;
   logic             tmr_en;
   logic             tmr_tc;
   logic [CNT_W-1:0] tmr_term;
   logic             addr_ok;
   logic             done_hit;
   logic             busy;

   assign state    = st;
   assign tmr_en   = (st == ST_RECEIVE) || (st == ST_WAIT);
   assign tmr_term = (st == ST_WAIT) ? PERIOD_TC : TIMEOUT_TC;
   assign addr_ok  = {1'b0, cmd_addr} < N_CH_A;
   // sensor_start is one-hot on the latched channel, so this masks other channels.
   assign done_hit = |(sensor_done & sensor_start);
   assign busy     = (st == ST_RECEIVE) || (st == ST_ORGANIZE) || (st == ST_SEND);

   interval_timer #(.W(CNT_W)) u_timer (
      .clk_50m (clk_50m),
      .rst_n   (rst_n),
      .clr     (tmr_clr),
      .en      (tmr_en),
      .term    (tmr_term),
      .tc      (tmr_tc)
   );

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         st           <= ST_IDLE;
         idle         <= 1'b1;
         sensor_start <= '0;
         pack         <= 1'b0;
         en_request   <= 1'b0;
         status       <= STATUS_OK;
         cont_active  <= 1'b0;
         cmd_dropped  <= 1'b0;
         ch           <= '0;
         tmr_clr      <= 1'b0;
      end else begin
         pack        <= 1'b0;
         cmd_dropped <= 1'b0;
         tmr_clr     <= 1'b0;

         // Commands arriving mid-transaction are dropped, but a stop still ends the loop.
         if (cmd_valid && busy) begin
            cmd_dropped <= 1'b1;
            if (cmd_stop) cont_active <= 1'b0;
         end

         case (st)
            ST_IDLE, ST_WAIT: begin
               if (cmd_valid) begin
                  tmr_clr <= 1'b1;
                  idle    <= 1'b0;
                  if (cmd_stop) begin
                     st          <= ST_ORGANIZE;
                     status      <= STATUS_STOP_ACK;
                     pack        <= 1'b1;
                     cont_active <= 1'b0;
                  end else if (!addr_ok) begin
                     st     <= ST_ORGANIZE;
                     status <= STATUS_BAD_ADDR;
                     pack   <= 1'b1;
                  end else begin
                     st           <= ST_RECEIVE;
                     ch           <= CH_W'(cmd_addr);
                     cont_active  <= cmd_cont;
                     sensor_start <= CH0 << cmd_addr;
                  end
               end else if (tmr_tc) begin
                  st           <= ST_RECEIVE;
                  tmr_clr      <= 1'b1;
                  sensor_start <= CH0 << ch;
               end
            end
            ST_RECEIVE: begin
               if (done_hit || tmr_tc) begin
                  st           <= ST_ORGANIZE;
                  tmr_clr      <= 1'b1;
                  pack         <= 1'b1;
                  sensor_start <= '0;
                  status       <= done_hit ? STATUS_OK : STATUS_TIMEOUT;
               end
            end
            ST_ORGANIZE: begin
               st         <= ST_SEND;
               tmr_clr    <= 1'b1;
               en_request <= 1'b1;
            end
            ST_SEND: begin
               if (tx_done) begin
                  en_request <= 1'b0;
                  tmr_clr    <= 1'b1;
                  if (cont_active && !(cmd_valid && cmd_stop)) begin
                     st <= ST_WAIT;
                  end else begin
                     st   <= ST_IDLE;
                     idle <= 1'b1;
                  end
               end
            end
            default: begin
               st           <= ST_IDLE;
               idle         <= 1'b1;
               sensor_start <= '0;
               en_request   <= 1'b0;
               tmr_clr      <= 1'b1;
            end
         endcase
      end
   end

endmodule
